// File: rtl/wb_frame_reader.sv
// Wishbone classic master that streams a frame buffer, word by word, into a
// show-ahead output FIFO tagged with a start-of-frame flag.
module wb_frame_reader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned FRAME_WORDS = 307200,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [3:0]  wb_sel,
    output logic [31:0] wb_adr,
    output logic [31:0] wb_dat_ms,
    input  logic [31:0] wb_dat_sm,
    input  logic        wb_ack,
    output logic [31:0] pix_data,
    output logic        pix_sof,
    output logic        pix_valid,
    input  logic        pix_ready
);

    localparam int unsigned IDX_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [31:0]      r_adr;
    logic [IDX_W-1:0] r_word_idx;
    logic [32:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             w_push;
    logic             w_pop;
    logic [32:0]      w_head;

    assign w_push = (r_state == READ) && wb_ack;
    assign w_pop  = pix_valid && pix_ready;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Staying in READ uses the post-edge count, so a request is never
    // outstanding without a guaranteed free FIFO slot.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (enable && (r_count < DEPTH_C))
                    w_state_next = READ;
            end
            READ: begin
                if (wb_ack)
                    w_state_next = (enable && (w_count_next < DEPTH_C)) ? READ : IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_adr      <= BASE_ADDR;
            r_word_idx <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
                if (r_word_idx == LAST_IDX) begin
                    r_word_idx <= '0;
                    r_adr      <= BASE_ADDR;
                end else begin
                    r_word_idx <= r_word_idx + IDX_W'(1);
                    r_adr      <= r_adr + 32'd4;
                end
            end
            if (w_pop)
                r_rptr <= r_rptr + PTR_W'(1);
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !rst)
            r_mem[r_wptr] <= {(r_word_idx == '0), wb_dat_sm};
    end

    assign w_head    = r_mem[r_rptr];
    assign pix_data  = w_head[31:0];
    assign pix_sof   = w_head[32];
    assign pix_valid = (r_count != '0);

    assign wb_stb    = (r_state == READ);
    assign wb_cyc    = wb_stb;
    assign wb_adr    = r_adr;
    assign wb_we     = 1'b0;
    assign wb_sel    = 4'hF;
    assign wb_dat_ms = '0;

endmodule

// File: tb/tb_wb_frame_reader.sv
// Scoreboard bench for wb_frame_reader: a Wishbone slave returning data=address
// with programmable ack delay, and a reference model of the expected word stream.
module tb_wb_frame_reader;

    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int unsigned FW    = 4;
    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        wb_cyc, wb_stb, wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr, wb_dat_ms, wb_dat_sm;
    logic        wb_ack;
    logic [31:0] pix_data;
    logic        pix_sof, pix_valid;
    logic        pix_ready = 1'b0;

    wb_frame_reader #(
        .BASE_ADDR   (BASE),
        .FRAME_WORDS (FW),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_we     (wb_we),
        .wb_sel    (wb_sel),
        .wb_adr    (wb_adr),
        .wb_dat_ms (wb_dat_ms),
        .wb_dat_sm (wb_dat_sm),
        .wb_ack    (wb_ack),
        .pix_data  (pix_data),
        .pix_sof   (pix_sof),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave: ack after cur_delay wait cycles, data mirrors the address.
    int unsigned fix_delay = 0;
    int unsigned rnd_delay = 0;
    logic        rand_mode = 1'b0;
    int unsigned slv_wait  = 0;
    int unsigned cur_delay;

    assign cur_delay = rand_mode ? rnd_delay : fix_delay;
    assign wb_ack    = wb_stb && (slv_wait == cur_delay);
    assign wb_dat_sm = wb_adr;

    always @(posedge clk) begin
        if (rst || !wb_stb || wb_ack)
            slv_wait <= 0;
        else
            slv_wait <= slv_wait + 1;
        if (wb_ack)
            rnd_delay <= $urandom_range(0, 3);
    end

    // Reference model and scoreboard
    logic [32:0] exp_q [$];
    logic [31:0] ack_log [$];
    int unsigned exp_idx   = 0;
    int unsigned hold_cnt  = 0;
    int          ack_cnt   = 0;
    int          pop_cnt   = 0;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_adr  = '0;
    logic [31:0] last_ack_adr = '0;

    always @(negedge clk) begin
        logic [32:0] e;
        logic [31:0] a;
        if (rst) begin
            exp_q.delete();
            exp_idx   = 0;
            hold_cnt  = 0;
            prev_wait = 1'b0;
        end else begin
            check("pix_valid", pix_valid, exp_q.size() != 0);
            if (pix_valid && pix_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pix_data", pix_data, e[31:0]);
                check("pix_sof", pix_sof, e[32]);
                pop_cnt++;
            end
            if (prev_wait) begin
                check("stb_hold", wb_stb, 1);
                check("adr_hold", wb_adr, prev_adr);
            end
            if (wb_stb) begin
                check("rd_while_full", exp_q.size() < DEPTH, 1);
                check("cyc_eq_stb", wb_cyc, wb_stb);
            end
            if (wb_stb && wb_ack) begin
                a = BASE + 32'(4 * exp_idx);
                check("wb_adr", wb_adr, a);
                check("wait_cycles", hold_cnt, cur_delay);
                exp_q.push_back({exp_idx == 0, a});
                ack_log.push_back(wb_adr);
                last_ack_adr = wb_adr;
                exp_idx  = (exp_idx + 1) % FW;
                hold_cnt = 0;
                ack_cnt++;
            end else if (wb_stb) begin
                hold_cnt++;
            end
            prev_wait = wb_stb && !wb_ack;
            prev_adr  = wb_adr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        enable = 1'b0;
        rst    = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        enable    = 1'b0;
        pix_ready = 1'b1;
        n = 0;
        while ((wb_stb || exp_q.size() != 0 || pix_valid) && n < 100) begin
            tick();
            n++;
        end
        check("drain_timeout", n < 100, 1);
    endtask

    task automatic wait_acks(input int target, input string tag);
        int n;
        n = 0;
        while (ack_cnt < target && n < 500) begin
            tick();
            n++;
        end
        check(tag, ack_cnt >= target, 1);
    endtask

    task automatic wait_stb_at(input logic [31:0] adr, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!(wb_stb && wb_adr == adr) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, n < 200, 1);
    endtask

    initial begin
        logic [31:0] exp_seq [5];
        int base_i, base_a, base_p, n;

        exp_seq = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h100};

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_stb", wb_stb, 0);
        check("rst_cyc", wb_cyc, 0);
        check("rst_valid", pix_valid, 0);
        check("rst_adr", wb_adr, BASE);
        check("wb_we", wb_we, 0);
        check("wb_sel", wb_sel, 4'hF);
        check("wb_dat_ms", wb_dat_ms, 0);

        // Basic fetch with zero-wait slave, including the frame wrap
        tick();
        fix_delay = 0;
        pix_ready = 1'b1;
        base_i    = ack_log.size();
        enable    = 1'b1;
        @(negedge clk);
        check("lat_stb_before", wb_stb, 0);
        @(negedge clk);
        check("lat_stb_after", wb_stb, 1);
        wait_acks(5, "basic_timeout");
        drain();
        for (int k = 0; k < 5; k++)
            check("basic_seq", ack_log[base_i + k], exp_seq[k]);

        // Backpressure: FIFO fills, reads stop, one pop releases one read
        pix_ready = 1'b0;
        base_a    = ack_cnt;
        enable    = 1'b1;
        for (int k = 0; k < 30; k++) tick();
        @(negedge clk);
        check("bp_acks", ack_cnt - base_a, DEPTH);
        check("bp_stb", wb_stb, 0);
        check("bp_valid", pix_valid, 1);
        tick();
        pix_ready = 1'b1;
        tick();
        pix_ready = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("bp_one_more", ack_cnt - base_a, DEPTH + 1);
        drain();

        // Slow slave: three wait states per word
        fix_delay = 3;
        base_a    = ack_cnt;
        base_p    = pop_cnt;
        enable    = 1'b1;
        wait_acks(base_a + 5, "slow_timeout");
        drain();
        check("slow_words", pop_cnt - base_p, ack_cnt - base_a);

        // Enable dropped while waiting on the ack at 0x108
        do_reset();
        fix_delay = 3;
        enable    = 1'b1;
        wait_stb_at(32'h108, "drop_find");
        tick();
        enable = 1'b0;
        n = 0;
        @(negedge clk);
        while (!(wb_stb && wb_ack) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drop_ack_timeout", n < 50, 1);
        @(negedge clk);
        check("drop_stb", wb_stb, 0);
        check("drop_last_adr", last_ack_adr, 32'h108);
        drain();
        tick();
        enable = 1'b1;
        n = 0;
        @(negedge clk);
        while (!wb_stb && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("resume_adr", wb_adr, 32'h10C);
        drain();

        // Reset in the middle of a read at 0x104
        do_reset();
        fix_delay = 3;
        enable    = 1'b1;
        wait_stb_at(32'h104, "rst_find");
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("rstmid_stb", wb_stb, 0);
        check("rstmid_valid", pix_valid, 0);
        check("rstmid_adr", wb_adr, BASE);
        tick();
        rst = 1'b0;
        n = 0;
        @(negedge clk);
        while (!wb_stb && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rstmid_first_adr", wb_adr, BASE);
        base_a = ack_cnt;
        wait_acks(base_a + 1, "rstmid_ack_timeout");
        check("rstmid_ack_adr", last_ack_adr, BASE);
        drain();

        // Random ready and random ack delay across three frames
        rand_mode = 1'b1;
        base_p    = pop_cnt;
        enable    = 1'b1;
        n = 0;
        while (pop_cnt - base_p < 3 * FW + 2 && n < 3000) begin
            tick();
            pix_ready = 1'($urandom_range(0, 1));
            n++;
        end
        check("rand_timeout", n < 3000, 1);
        drain();
        rand_mode = 1'b0;
        check("final_balance", pop_cnt, ack_cnt);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_frame_reader.md
WB_FRAME_READER -- requirements
Module: wb_frame_reader

Interface
Parameters:
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte address of the first frame word; must be a multiple of 4.
REQ-002 The block SHALL have parameter FRAME_WORDS, default 307200, giving the number of 32-bit words per frame; legal values are 2 to 2^20.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8, giving the output FIFO depth in words; must be a power of 2 and at least 2.

Ports:
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port enable, input, 1 bit: fetch enable.
REQ-007 The block SHALL have port wb_cyc, output, 1 bit: Wishbone cycle.
REQ-008 The block SHALL have port wb_stb, output, 1 bit: Wishbone strobe.
REQ-009 The block SHALL have port wb_we, output, 1 bit: write enable, held at 0.
REQ-010 The block SHALL have port wb_sel, output, 4 bits: byte select, held at 4'hF.
REQ-011 The block SHALL have port wb_adr, output, 32 bits: byte address.
REQ-012 The block SHALL have port wb_dat_ms, output, 32 bits: master-to-slave data, held at 0.
REQ-013 The block SHALL have port wb_dat_sm, input, 32 bits: read data.
REQ-014 The block SHALL have port wb_ack, input, 1 bit: cycle acknowledge.
REQ-015 The block SHALL have port pix_data, output, 32 bits: head word of the FIFO.
REQ-016 The block SHALL have port pix_sof, output, 1 bit: marks the head word as word 0 of a frame.
REQ-017 The block SHALL have port pix_valid, output, 1 bit: FIFO not empty.
REQ-018 The block SHALL have port pix_ready, input, 1 bit: consumer accepts the head word.

Function
REQ-019 The block SHALL act as a 32-bit Wishbone classic master issuing single-beat reads only, keeping wb_cyc identical to wb_stb.
REQ-020 The block SHALL implement an FSM with states IDLE and READ.
- IDLE: wb_stb=0.
- IDLE->READ on the next edge when enable=1 and (fifo_count + 0) < FIFO_DEPTH.
REQ-021 In READ, the block SHALL hold wb_stb=1 and wb_adr stable until wb_ack=1, with no timeout.
REQ-022 On an ack edge, the block SHALL perform all of the following:
- push {sof_flag, wb_dat_sm} into the FIFO;
- advance word_idx and wb_adr by 4.
REQ-023 The block SHALL stay in READ (back-to-back, new address on the next cycle) if enable=1 and fifo_count after this edge's push/pop < FIFO_DEPTH, and otherwise go to IDLE.
REQ-024 The block SHALL set sof_flag=1 exactly when word_idx==0.
REQ-025 Wrap: when the ack is for word_idx==FRAME_WORDS-1, the block SHALL set word_idx to 0 and wb_adr to BASE_ADDR, with no gap cycle.
REQ-026 The block SHALL never issue a request while the FIFO is full, so at most one read is outstanding and it always has a free slot.
REQ-027 Enable deasserted during READ: the block SHALL complete the current cycle and push its data, then return to IDLE with address and word_idx retained.
REQ-028 Re-enable: the block SHALL resume at the retained address, with no frame restart.
REQ-029 The FIFO SHALL be show-ahead: pix_data/pix_sof show the head word combinationally and pix_valid = (count != 0).
REQ-030 A pop SHALL occur on an edge with pix_valid & pix_ready; pix_ready with pix_valid=0 SHALL have no effect.
REQ-031 Simultaneous push and pop SHALL leave count unchanged and preserve data order; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-032 Latency: wb_stb SHALL rise 1 cycle after enable rises (FIFO not full), and a word SHALL be visible on pix_data 1 cycle after its ack edge.

Reset
REQ-033 When rst=1 at an edge, the block SHALL set state=IDLE, wb_cyc=wb_stb=0, wb_adr=BASE_ADDR, word_idx=0, FIFO count=0 and pointers=0, giving pix_valid=0.
REQ-034 Reset during READ SHALL abandon the cycle immediately: wb_stb drops next cycle, the in-flight data is discarded, and a wb_ack during reset is ignored.
REQ-035 The block SHALL hold wb_we=0, wb_sel=4'hF and wb_dat_ms=0 at all times.

Verification
REQ-036 Basic fetch: FRAME_WORDS=4, BASE=0x100, slave acks each request in the same cycle with data=address, pix_ready=1 -> wb_adr sequence 0x100,0x104,0x108,0x10C,0x100; pix_data follows the same sequence, with pix_sof=1 on 0x100 only.
REQ-037 Backpressure: FIFO_DEPTH=8, pix_ready=0 -> exactly 8 acks, then wb_stb=0 and pix_valid=1; after one pix_ready pulse, exactly one new read is issued.
REQ-038 Slow slave: ack after 3 wait cycles -> wb_adr/wb_stb stable for 4 cycles per word, with no duplicate or missing FIFO words.
REQ-039 Enable drop mid-cycle: enable=0 while waiting for the ack at 0x108 -> the ack is accepted, word 0x108 is pushed, wb_stb=0 next cycle; re-enable -> the next read is at 0x10C.
REQ-040 Reset mid-read: rst=1 while wb_stb=1 at 0x104 -> next cycle wb_stb=0, pix_valid=0, wb_adr=0x100; after rst=0 the first read is at 0x100 with sof=1.
REQ-041 Scoreboard: random pix_ready and random ack delay over 3 frames -> the output stream equals the address sequence modulo the frame, and there is no read while count==FIFO_DEPTH.
